// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA encryption engine.
//   DEFAULT_WIDTH : default data/key width
//   E_START       : first public-exponent candidate tried
//   PHI_MIN       : smallest totient that still leaves room for a valid e
//   state_t       : top-level FSM encoding
package rsa_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned E_START       = 2;
    localparam int unsigned PHI_MIN       = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEL_E,
        MODEXP,
        DONE
    } state_t;

endpackage

// File: rtl/gcd_unit.sv
// Iterative Euclid GCD: one (a, b) <= (b, a mod b) step per cycle until b = 0.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   start : load operands a, b (restarts any computation in flight)
//   a, b  : operands
//   done  : one-cycle pulse when g is valid
//   g     : gcd(a, b); gcd(a, 0) = a
module gcd_unit
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] g
);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             running;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r     <= '0;
            b_r     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            g       <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_r     <= a;
                b_r     <= b;
                running <= 1'b1;
            end else if (running) begin
                if (b_r == '0) begin
                    done    <= 1'b1;
                    g       <= a_r;
                    running <= 1'b0;
                end else begin
                    a_r <= b_r;
                    b_r <= a_r % b_r;
                end
            end
        end
    end

endmodule

// File: rtl/rsa_encryption.sv
// RSA encryption engine: derives n = p*q, phi = (p-1)(q-1), picks the smallest e > 1
// coprime to phi, then computes c = m^e mod n with a fixed-length square-and-multiply.
//   clk, rst         : clock, asynchronous active-low reset
//   start            : begin encryption (accepted only in IDLE or DONE)
//   p_val, q_val     : primes p, q
//   m_data           : plaintext
//   e_key, e_data    : public exponent, ciphertext
//   nval, phival     : modulus, totient
//   enc_done         : level, high while in DONE
//   busy             : high in SETUP, SEL_E, MODEXP
//   err              : valid with enc_done; 1 = no usable key
module rsa_encryption
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] p_val,
    input  logic [WIDTH-1:0] q_val,
    input  logic [WIDTH-1:0] m_data,
    output logic [WIDTH-1:0] e_key,
    output logic [WIDTH-1:0] e_data,
    output logic [WIDTH-1:0] nval,
    output logic [WIDTH-1:0] phival,
    output logic             enc_done,
    output logic             busy,
    output logic             err
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_in;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] cand_e;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp_r;
    logic [CW-1:0]    step_cnt;

    logic             gcd_start;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_g;

    // Setup datapath, operating on the captured operands.
    logic [W2-1:0]    pq_full;
    logic [WIDTH-1:0] n_low;
    logic [WIDTH-1:0] phi_low;
    logic [WIDTH-1:0] m_red;
    logic             setup_bad;

    always_comb begin
        pq_full   = W2'(p_r) * W2'(q_r);
        n_low     = pq_full[WIDTH-1:0];
        phi_low   = (p_r - WIDTH'(1)) * (q_r - WIDTH'(1));
        // n = 0 only on overflow, which is an error path anyway; avoid mod-by-zero.
        m_red     = (n_low == '0) ? '0 : (m_in % n_low);
        setup_bad = (p_r < WIDTH'(2)) || (q_r < WIDTH'(2))
                 || (pq_full[W2-1:WIDTH] != '0)
                 || (phi_low < WIDTH'(PHI_MIN));
    end

    // Two independent mulmod paths: multiply step and squaring step.
    logic [W2-1:0]    n_wide;
    logic [WIDTH-1:0] acc_mul_red;
    logic [WIDTH-1:0] base_sq_red;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        n_wide = W2'(nval);
        if (n_wide == '0) begin
            acc_mul_red = '0;
            base_sq_red = '0;
        end else begin
            acc_mul_red = WIDTH'((W2'(acc) * W2'(base)) % n_wide);
            base_sq_red = WIDTH'((W2'(base) * W2'(base)) % n_wide);
        end
        acc_next = exp_r[0] ? acc_mul_red : acc;
    end

    gcd_unit #(
        .WIDTH (WIDTH)
    ) u_gcd (
        .clk   (clk),
        .rst   (rst),
        .start (gcd_start),
        .a     (phival),
        .b     (cand_e),
        .done  (gcd_done),
        .g     (gcd_g)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            p_r       <= '0;
            q_r       <= '0;
            m_in      <= '0;
            m_r       <= '0;
            cand_e    <= '0;
            acc       <= '0;
            base      <= '0;
            exp_r     <= '0;
            step_cnt  <= '0;
            gcd_start <= 1'b0;
            e_key     <= '0;
            e_data    <= '0;
            nval      <= '0;
            phival    <= '0;
            enc_done  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        p_r      <= p_val;
                        q_r      <= q_val;
                        m_in     <= m_data;
                        e_key    <= '0;
                        e_data   <= '0;
                        enc_done <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    nval   <= n_low;
                    phival <= phi_low;
                    m_r    <= m_red;
                    if (setup_bad) begin
                        err      <= 1'b1;
                        enc_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cand_e    <= WIDTH'(E_START);
                        gcd_start <= 1'b1;
                        state     <= SEL_E;
                    end
                end

                SEL_E: begin
                    gcd_start <= 1'b0;
                    if (gcd_done) begin
                        if (gcd_g == WIDTH'(1)) begin
                            e_key    <= cand_e;
                            acc      <= WIDTH'(1);
                            base     <= m_r;
                            exp_r    <= cand_e;
                            step_cnt <= '0;
                            state    <= MODEXP;
                        end else if (cand_e + WIDTH'(1) >= phival) begin
                            err      <= 1'b1;
                            enc_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            cand_e    <= cand_e + WIDTH'(1);
                            gcd_start <= 1'b1;
                        end
                    end
                end

                MODEXP: begin
                    // Always WIDTH steps so the latency does not depend on e.
                    acc      <= acc_next;
                    base     <= base_sq_red;
                    exp_r    <= exp_r >> 1;
                    step_cnt <= step_cnt + CW'(1);
                    if (step_cnt == CW'(WIDTH - 1)) begin
                        e_data   <= acc_next;
                        enc_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_encryption.sv
// Directed self-checking bench for rsa_encryption (WIDTH = 32).
// Latency is counted in clock edges after the edge that accepts start; with
// each gcd attempt taking 3 + (Euclid steps) cycles, T1 (phi=6, e tried 2..5)
// spends 1 + 18 + 32 = 51 cycles, and p=3,q=11 (phi=20, e tried 2..3) 1 + 10 + 32 = 43.
module tb_rsa_encryption;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] p_val = '0;
    logic [W-1:0] q_val = '0;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] e_key;
    logic [W-1:0] e_data;
    logic [W-1:0] nval;
    logic [W-1:0] phival;
    logic         enc_done;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    rsa_encryption #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .p_val    (p_val),
        .q_val    (q_val),
        .m_data   (m_data),
        .e_key    (e_key),
        .e_data   (e_data),
        .nval     (nval),
        .phival   (phival),
        .enc_done (enc_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic longint unsigned mod_pow(input longint unsigned b,
                                                input longint unsigned e,
                                                input longint unsigned n);
        longint unsigned r = 1;
        longint unsigned x = b % n;
        longint unsigned k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % n;
            x = (x * x) % n;
            k = k >> 1;
        end
        return r;
    endfunction

    // Returns after the edge that accepted start (on the following falling edge).
    task automatic pulse_start(input logic [W-1:0] p, input logic [W-1:0] q,
                               input logic [W-1:0] m);
        @(negedge clk);
        p_val  = p;
        q_val  = q;
        m_data = m;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (enc_done === 1'b1) break;
        end
        if (enc_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: enc_done=%b required 1 within 2000 cycles", enc_done);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({e_key, e_data, nval, phival, enc_done, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: e_key=%0d e_data=%0d n=%0d phi=%0d done=%b busy=%b err=%b required all 0",
                     e_key, e_data, nval, phival, enc_done, busy, err);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        int d;
        longint unsigned dec;
        pulse_start(32'd2, 32'd7, 32'd2);
        checks++;
        if (busy !== 1'b1 || enc_done !== 1'b0) begin
            errors++;
            $display("FAIL t1_busy: busy=%b done=%b required busy=1 done=0", busy, enc_done);
        end
        wait_done(lat);
        checks++;
        if (lat != 51) begin
            errors++;
            $display("FAIL t1_latency: got %0d required 51", lat);
        end
        checks++;
        if (nval !== 32'd14 || phival !== 32'd6) begin
            errors++;
            $display("FAIL t1_n_phi: n=%0d phi=%0d required 14 6", nval, phival);
        end
        checks++;
        if (e_key !== 32'd5 || e_data !== 32'd4) begin
            errors++;
            $display("FAIL t1_key_data: e=%0d c=%0d required 5 4", e_key, e_data);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_flags: err=%b busy=%b required 0 0", err, busy);
        end
        // Decryption side: d = e^-1 mod phi, m' = c^d mod n must recover 2.
        d = 0;
        for (int k = 1; k < 64; k++) begin
            if ((int'(e_key) * k) % (int'(phival) == 0 ? 1 : int'(phival)) == 1) begin
                d = k;
                break;
            end
        end
        dec = (nval == 0) ? 64'd0 : mod_pow(longint'(e_data), longint'(d), longint'(nval));
        checks++;
        if (dec != 64'd2) begin
            errors++;
            $display("FAIL t1_decrypt: d_data=%0d required 2", dec);
        end
    endtask

    task automatic test_modexp;
        logic [W-1:0] vp  [2] = '{32'd3, 32'd5};
        logic [W-1:0] vq  [2] = '{32'd11, 32'd11};
        logic [W-1:0] vm  [2] = '{32'd7, 32'd2};
        logic [W-1:0] xn  [2] = '{32'd33, 32'd55};
        logic [W-1:0] xph [2] = '{32'd20, 32'd40};
        logic [W-1:0] xe  [2] = '{32'd3, 32'd3};
        logic [W-1:0] xc  [2] = '{32'd13, 32'd8};
        int lat;
        for (int i = 0; i < 2; i++) begin
            pulse_start(vp[i], vq[i], vm[i]);
            wait_done(lat);
            checks++;
            if (nval !== xn[i] || phival !== xph[i] || e_key !== xe[i] || e_data !== xc[i]
                || err !== 1'b0) begin
                errors++;
                $display("FAIL t2_vec%0d: n=%0d phi=%0d e=%0d c=%0d err=%b required %0d %0d %0d %0d 0",
                         i, nval, phival, e_key, e_data, err, xn[i], xph[i], xe[i], xc[i]);
            end
        end
    endtask

    task automatic test_reduce;
        int lat;
        pulse_start(32'd2, 32'd7, 32'd16);
        wait_done(lat);
        checks++;
        if (e_data !== 32'd4 || e_key !== 32'd5) begin
            errors++;
            $display("FAIL t3_m_ge_n: c=%0d e=%0d required 4 5", e_data, e_key);
        end
        pulse_start(32'd2, 32'd7, 32'd0);
        wait_done(lat);
        checks++;
        if (e_data !== 32'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL t3_m_zero: c=%0d err=%b required 0 0", e_data, err);
        end
    endtask

    task automatic test_errors;
        int lat;
        pulse_start(32'd2, 32'd2, 32'd1);
        wait_done(lat);
        checks++;
        if (err !== 1'b1 || e_key !== 32'd0 || e_data !== 32'd0 || phival !== 32'd1
            || nval !== 32'd4 || lat != 1) begin
            errors++;
            $display("FAIL t4_phi_small: err=%b e=%0d c=%0d phi=%0d n=%0d lat=%0d required 1 0 0 1 4 1",
                     err, e_key, e_data, phival, nval, lat);
        end
        pulse_start(32'd65537, 32'd65537, 32'd5);
        wait_done(lat);
        checks++;
        if (err !== 1'b1 || e_key !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_overflow: err=%b e=%0d busy=%b required 1 0 0", err, e_key, busy);
        end
        pulse_start(32'd1, 32'd7, 32'd5);
        wait_done(lat);
        checks++;
        if (err !== 1'b1 || e_key !== 32'd0) begin
            errors++;
            $display("FAIL t4_p_lt_2: err=%b e=%0d required 1 0", err, e_key);
        end
    endtask

    task automatic test_abort;
        int lat;
        pulse_start(32'd2, 32'd7, 32'd2);
        // MODEXP is entered at edge 19; stop two steps in.
        repeat (21) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || e_key !== 32'd5) begin
            errors++;
            $display("FAIL t5_in_modexp: busy=%b e=%0d required 1 5", busy, e_key);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({e_key, e_data, nval, phival, enc_done, busy, err} !== '0) begin
            errors++;
            $display("FAIL t5_abort: e=%0d c=%0d n=%0d phi=%0d done=%b busy=%b err=%b required all 0",
                     e_key, e_data, nval, phival, enc_done, busy, err);
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_start(32'd2, 32'd7, 32'd2);
        wait_done(lat);
        checks++;
        if (e_key !== 32'd5 || e_data !== 32'd4 || nval !== 32'd14 || lat != 51) begin
            errors++;
            $display("FAIL t5_rerun: e=%0d c=%0d n=%0d lat=%0d required 5 4 14 51",
                     e_key, e_data, nval, lat);
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        pulse_start(32'd2, 32'd7, 32'd2);
        lat = 0;
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        p_val  = 32'd3;
        q_val  = 32'd11;
        m_data = 32'd7;
        start  = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (enc_done !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (enc_done !== 1'b1 || e_key !== 32'd5 || e_data !== 32'd4 || nval !== 32'd14
            || lat != 51) begin
            errors++;
            $display("FAIL t6_ignore_start: done=%b e=%0d c=%0d n=%0d lat=%0d required 1 5 4 14 51",
                     enc_done, e_key, e_data, nval, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        // Engine is sitting in DONE from the previous run.
        pulse_start(32'd3, 32'd11, 32'd7);
        checks++;
        if (enc_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t6_restart_flags: done=%b busy=%b required 0 1", enc_done, busy);
        end
        wait_done(lat);
        checks++;
        if (e_key !== 32'd3 || e_data !== 32'd13 || nval !== 32'd33 || lat != 43) begin
            errors++;
            $display("FAIL t6_back_to_back: e=%0d c=%0d n=%0d lat=%0d required 3 13 33 43",
                     e_key, e_data, nval, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modexp();
        test_reduce();
        test_errors();
        test_abort();
        test_busy_ignore();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
